// File: rtl/debug_dec_formatter.sv
// ============================================================================
// Module      : debug_dec_formatter
// Description : Converts a signed word to ASCII decimal characters with a
//               shift-add-3 engine. Optional macro: LEADING_ZERO_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_dec_formatter #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic [3:0]        out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam int c_cnt_w = $clog2(DATA_W);
    localparam int c_bcd_w = 4 * DIGITS;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_convert = 2'd1;
    localparam logic [1:0] c_st_emit    = 2'd2;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);
    localparam logic [3:0]         c_idx_last = 4'(DIGITS);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_sign;
    logic [DATA_W-1:0]  r_mag;
    logic [c_bcd_w-1:0] r_bcd;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_idx;

    logic [DATA_W-1:0]  w_mag;
    logic [c_bcd_w-1:0] w_bcd_adj;
    logic [7:0]         w_chars [0:DIGITS];

    // Most negative input negates to itself, which reads correctly as unsigned.
    assign w_mag = in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;

    for (genvar j = 0; j < DIGITS; j++) begin : g_adj
        assign w_bcd_adj[4*j +: 4] = (r_bcd[4*j +: 4] >= 4'd5) ?
                                     (r_bcd[4*j +: 4] + 4'd3) : r_bcd[4*j +: 4];
    end

    assign w_chars[0] = r_sign ? 8'h2D : 8'h2B;

`ifdef LEADING_ZERO_BLANK_EN
    // w_zero_above[j]: nibble j and every more significant nibble are zero.
    logic [DIGITS:0] w_zero_above;
    assign w_zero_above[DIGITS] = 1'b1;
    for (genvar j = 0; j < DIGITS; j++) begin : g_zero
        assign w_zero_above[j] = w_zero_above[j+1] & (r_bcd[4*j +: 4] == 4'd0);
    end
    for (genvar k = 1; k <= DIGITS; k++) begin : g_chr
        if (k < DIGITS) begin : g_blankable
            assign w_chars[k] = w_zero_above[DIGITS-k] ? 8'h20 :
                                {4'h3, r_bcd[4*(DIGITS-k) +: 4]};
        end else begin : g_units
            assign w_chars[k] = {4'h3, r_bcd[4*(DIGITS-k) +: 4]};
        end
    end
`else
    for (genvar k = 1; k <= DIGITS; k++) begin : g_chr
        assign w_chars[k] = {4'h3, r_bcd[4*(DIGITS-k) +: 4]};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (in_valid)                         w_state_nxt = c_st_convert;
            c_st_convert: if (r_cnt == c_cnt_last)              w_state_nxt = c_st_emit;
            c_st_emit:    if (out_ready && r_idx == c_idx_last) w_state_nxt = c_st_idle;
            default:                                            w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_sign <= in_data[DATA_W-1];
                        r_mag  <= w_mag;
                        r_bcd  <= '0;
                        r_cnt  <= '0;
                        r_idx  <= '0;
                    end
                end
                c_st_convert: begin
                    {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
                    r_cnt          <= r_cnt + 1'b1;
                end
                c_st_emit: begin
                    if (out_ready) begin
                        r_idx <= (r_idx == c_idx_last) ? 4'd0 : r_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == c_st_idle);
        busy      = (r_state != c_st_idle);
        out_valid = (r_state == c_st_emit);
        out_idx   = out_valid ? r_idx : 4'd0;
        out_char  = out_valid ? w_chars[r_idx] : 8'h00;
        out_last  = out_valid && (r_idx == c_idx_last);
    end

endmodule

`default_nettype wire

// File: tb/tb_debug_dec_formatter.sv
// ============================================================================
// Module      : tb_debug_dec_formatter
// Description : Scoreboard bench for debug_dec_formatter with a decimal model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_dec_formatter;

    localparam int DATA_W = 32;
    localparam int DIGITS = 10;

    typedef struct {
        logic [7:0] ch;
        logic [3:0] idx;
        logic       last;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_char;
    logic [3:0]        out_idx;
    logic              out_last;
    logic              busy;

    logic man_ready;
    logic rnd_ready;
    logic rnd_bit;
    assign out_ready = rnd_ready ? rnd_bit : man_ready;

    exp_t q[$];
    int   total;
    int   bad;

    debug_dec_formatter #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by repeated division of the true magnitude.
    task automatic push_expected(input logic [31:0] v);
        longint sv;
        longint mag;
        int     d [1:DIGITS];
        exp_t   e;
`ifdef LEADING_ZERO_BLANK_EN
        bit     lead;
`endif
        sv  = longint'($signed(v));
        mag = (sv < 0) ? -sv : sv;
        for (int k = DIGITS; k >= 1; k--) begin
            d[k] = int'(mag % 10);
            mag  = mag / 10;
        end
        e.ch   = (sv < 0) ? 8'h2D : 8'h2B;
        e.idx  = 4'd0;
        e.last = 1'b0;
        q.push_back(e);
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
`endif
        for (int k = 1; k <= DIGITS; k++) begin
            e.ch = 8'h30 + 8'(d[k]);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && d[k] == 0 && k < DIGITS) e.ch = 8'h20;
            if (d[k] != 0) lead = 1'b0;
`endif
            e.idx  = 4'(k);
            e.last = (k == DIGITS);
            q.push_back(e);
        end
    endtask

    // Monitor: pops on every transfer and checks hold-stability during stalls.
    initial begin
        exp_t       e;
        logic       stall_prev;
        logic [7:0] h_ch;
        logic [3:0] h_idx;
        logic       h_last;
        stall_prev = 1'b0;
        h_ch = '0; h_idx = '0; h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                check("ready_vs_busy", 32'(in_ready), 32'(!busy));
                if (out_valid && stall_prev) begin
                    check("hold_char", 32'(out_char), 32'(h_ch));
                    check("hold_idx",  32'(out_idx),  32'(h_idx));
                    check("hold_last", 32'(out_last), 32'(h_last));
                end
                if (out_valid && out_ready) begin
                    stall_prev = 1'b0;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_char actual=%0h idx=%0d required=none",
                                 out_char, out_idx);
                    end else begin
                        e = q.pop_front();
                        check("char", 32'(out_char), 32'(e.ch));
                        check("idx",  32'(out_idx),  32'(e.idx));
                        check("last", 32'(out_last), 32'(e.last));
                    end
                end else if (out_valid) begin
                    stall_prev = 1'b1;
                    h_ch = out_char; h_idx = out_idx; h_last = out_last;
                end else begin
                    stall_prev = 1'b0;
                end
            end
        end
    end

    // Called #1 after a rising edge; holds in_valid until the word is taken.
    task automatic send(input logic [31:0] v, input bit check_lat);
        int   n;
        logic saw_ready;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        push_expected(v);
        #1;
        in_valid = 1'b0;
        if (check_lat) begin
            n = 0;
            saw_ready = 1'b0;
            while (n < 100) begin
                if (in_ready) saw_ready = 1'b1;
                @(posedge clk);
                #1;
                n++;
                if (out_valid) break;
            end
            check("first_valid_latency", 32'(n), 32'(DATA_W));
            check("in_ready_in_convert", 32'(saw_ready), 32'd0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(q.size() == 0 && in_ready) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(n >= 3000), 32'd0);
    endtask

    task automatic wait_idx(input logic [3:0] k);
        int n;
        n = 0;
        while (!(out_valid && out_idx == k) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idx_timeout", 32'(n >= 200), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        man_ready = 1'b1;
        rnd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_char",  32'(out_char),  32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;

        send(32'h0000_0000, 1'b1);
        drain();
        send(32'hFFFF_FFFF, 1'b0);
        drain();
        send(32'h7FFF_FFFF, 1'b1);
        send(32'h8000_0000, 1'b0);
        drain();

        send(32'd12345, 1'b0);
        wait_idx(4'd6);
        man_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_char", 32'(out_char), 32'h31);
            check("stall_idx",  32'(out_idx),  32'd6);
        end
        man_ready = 1'b1;
        drain();

        send(32'hFFFF_D8F1, 1'b0);
        wait_idx(4'd4);
        rst = 1'b1;
        q.delete();
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_last",  32'(out_last),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'd7, 1'b0);
        drain();
        send(32'd42, 1'b0);
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            v = $urandom;
            if ($urandom_range(0, 3) == 0) v = 32'($urandom_range(0, 999));
            if ($urandom_range(0, 5) == 0) v = -32'($urandom_range(1, 999));
            send(v, 1'b0);
        end
        drain();
        rnd_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("end_queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
